ivl_uvm_window_arbiter: RTL and testbench

Round-robin arbiter that shares one request/acknowledge/response resource among NUM_REQ requesters. It opens exactly one transaction window at a time: start event, acknowledge held through the window, end event. A cycle-count timeout guards each window. It sits in front of the shared resource in the OVL test environment, so its resource-side outputs can be checked directly by ovl_window instances (start_event = rsc_req, test_expr = rsc_ack, end_event = rsc_resp).

---
 rtl/ivl_uvm_window_arbiter_if.sv | 44 ++++
 rtl/ivl_uvm_window_arbiter.sv | 141 ++++++++++++++
 tb/tb_ivl_uvm_window_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ivl_uvm_window_arbiter_if.sv
// Bundle between the window arbiter, its requesters and the shared resource.
// Latency: none, wires only.
// Backpressure: the resource closes a window with rsc_resp; requesters hold req_vec until granted.
interface ivl_uvm_window_arbiter_if #(
   parameter int NUM_REQ = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] req_vec;
   logic [NUM_REQ-1:0] gnt_vec;
   logic [ID_W-1:0]    gnt_id;
   logic               rsc_req;
   logic               rsc_ack;
   logic               rsc_resp;
   logic               busy;
   logic               timeout_err;
   logic               stray_resp;

   // Arbiter side
   modport master (
      input  req_vec,
      input  rsc_resp,
      output gnt_vec,
      output gnt_id,
      output rsc_req,
      output rsc_ack,
      output busy,
      output timeout_err,
      output stray_resp
   );

   // Requester / resource side
   modport slave (
      output req_vec,
      output rsc_resp,
      input  gnt_vec,
      input  gnt_id,
      input  rsc_req,
      input  rsc_ack,
      input  busy,
      input  timeout_err,
      input  stray_resp
   );
endinterface

// File: rtl/ivl_uvm_window_arbiter.sv
// Round-robin arbiter opening one req/ack/resp window at a time on a shared resource.
// Latency: request seen in IDLE -> rsc_req/rsc_ack/gnt_vec one cycle later; resp -> ack low next cycle.
// Backpressure: window held open until rsc_resp or TIMEOUT WAIT cycles; 1-cycle DONE gap between windows.
module ivl_uvm_window_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 16
) (
   input logic                      clock,
   input logic                      reset,
   ivl_uvm_window_arbiter_if.master bus
);
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_vec_q, gnt_vec_d;
   logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
   logic [ID_W-1:0]    last_id_q, last_id_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               rsc_req_q, rsc_req_d;
   logic               rsc_ack_q, rsc_ack_d;
   logic               busy_q, busy_d;
   logic               timeout_err_q, timeout_err_d;
   logic               stray_resp_q, stray_resp_d;

   logic [ID_W-1:0]    winner;
   logic [ID_W-1:0]    cand_id;
   int                 cand;

   // Round-robin pick: scan downwards so the candidate nearest after last_id wins
   always_comb begin
      winner  = '0;
      cand    = 0;
      cand_id = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand = int'(last_id_q) + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_id = ID_W'(cand);
         if (bus.req_vec[cand_id]) begin
            winner = cand_id;
         end
      end
   end

   // Next state and next registered outputs; outputs always reflect the state being entered
   always_comb begin
      state_d       = state_q;
      gnt_vec_d     = gnt_vec_q;
      gnt_id_d      = gnt_id_q;
      last_id_d     = last_id_q;
      count_d       = count_q;
      rsc_req_d     = 1'b0;
      rsc_ack_d     = rsc_ack_q;
      timeout_err_d = 1'b0;
      stray_resp_d  = 1'b0;

      case (state_q)
         IDLE: begin
            stray_resp_d = bus.rsc_resp;
            if (|bus.req_vec) begin
               gnt_id_d  = winner;
               gnt_vec_d = NUM_REQ'(1) << winner;
               rsc_req_d = 1'b1;
               rsc_ack_d = 1'b1;
               count_d   = '0;
               state_d   = START;
            end
         end
         START: begin
            // A resp here cannot be the end of this window: the resource has only just seen rsc_req
            stray_resp_d = bus.rsc_resp;
            count_d      = '0;
            state_d      = WAIT;
         end
         WAIT: begin
            if (bus.rsc_resp || (count_q == CNT_LAST)) begin
               timeout_err_d = ~bus.rsc_resp;
               gnt_vec_d     = '0;
               rsc_ack_d     = 1'b0;
               last_id_d     = gnt_id_q;
               state_d       = DONE;
            end else if (count_q != '1) begin
               count_d = count_q + 1'b1;
            end
         end
         DONE: begin
            stray_resp_d = bus.rsc_resp;
            state_d      = IDLE;
         end
         default: begin
            state_d   = IDLE;
            gnt_vec_d = '0;
            rsc_ack_d = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         gnt_vec_q     <= '0;
         gnt_id_q      <= '0;
         last_id_q     <= ID_LAST;
         count_q       <= '0;
         rsc_req_q     <= 1'b0;
         rsc_ack_q     <= 1'b0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         stray_resp_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         gnt_vec_q     <= gnt_vec_d;
         gnt_id_q      <= gnt_id_d;
         last_id_q     <= last_id_d;
         count_q       <= count_d;
         rsc_req_q     <= rsc_req_d;
         rsc_ack_q     <= rsc_ack_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
         stray_resp_q  <= stray_resp_d;
      end
   end

   assign bus.gnt_vec     = gnt_vec_q;
   assign bus.gnt_id      = gnt_id_q;
   assign bus.rsc_req     = rsc_req_q;
   assign bus.rsc_ack     = rsc_ack_q;
   assign bus.busy        = busy_q;
   assign bus.timeout_err = timeout_err_q;
   assign bus.stray_resp  = stray_resp_q;

endmodule

// File: tb/tb_ivl_uvm_window_arbiter.sv
// Directed bench for the window arbiter (NUM_REQ=4, TIMEOUT=16).
// Inputs driven 1 time unit after the rising edge, outputs checked there too.
// Event totals collected on the falling edge and compared as differences.
module tb_ivl_uvm_window_arbiter;
   logic clock;
   logic reset;

   ivl_uvm_window_arbiter_if #(.NUM_REQ(4)) bus ();

   ivl_uvm_window_arbiter #(
      .NUM_REQ (4),
      .TIMEOUT (16)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   // Event totals seen on the falling edge
   int         tot_req = 0;
   int         tot_ack = 0;
   int         tot_to = 0;
   int         tot_stray = 0;
   int         tot_multihot = 0;
   int         tot_abut = 0;
   logic       prev_ack = 1'b0;
   logic [1:0] grant_log[$];

   always @(negedge clock) begin
      if (bus.rsc_req) begin
         tot_req <= tot_req + 1;
         grant_log.push_back(bus.gnt_id);
         if (prev_ack) tot_abut <= tot_abut + 1;
      end
      if (bus.rsc_ack)          tot_ack <= tot_ack + 1;
      if (bus.timeout_err)      tot_to <= tot_to + 1;
      if (bus.stray_resp)       tot_stray <= tot_stray + 1;
      if (!$onehot0(bus.gnt_vec)) tot_multihot <= tot_multihot + 1;
      prev_ack <= bus.rsc_ack;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Advance until the START cycle of a window (rsc_req high), bounded
   task automatic wait_req(input string tag);
      int n = 0;
      while (!bus.rsc_req && n < 20) begin
         step();
         n++;
      end
      chk(tag, 32'(bus.rsc_req), 32'd1);
   endtask

   int s_req, s_ack, s_to, s_stray, s_mh, s_abut, base;
   int rr_exp[6] = '{0, 1, 3, 0, 1, 3};

   task automatic snap();
      s_req   = tot_req;
      s_ack   = tot_ack;
      s_to    = tot_to;
      s_stray = tot_stray;
      s_mh    = tot_multihot;
      s_abut  = tot_abut;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bus.req_vec = '0;
      bus.rsc_resp = 1'b0;
      step();
      step();

      // Reset values
      chk("rst_gnt_vec", 32'(bus.gnt_vec), 0);
      chk("rst_gnt_id", 32'(bus.gnt_id), 0);
      chk("rst_rsc_req", 32'(bus.rsc_req), 0);
      chk("rst_rsc_ack", 32'(bus.rsc_ack), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_timeout", 32'(bus.timeout_err), 0);
      chk("rst_stray", 32'(bus.stray_resp), 0);
      reset = 1'b0;
      step();

      // Single request, resp on 4th WAIT cycle -> ack high 5 cycles
      snap();
      bus.req_vec = 4'b0001;
      wait_req("t1_start");
      chk("t1_gnt_vec", 32'(bus.gnt_vec), 32'h1);
      chk("t1_gnt_id", 32'(bus.gnt_id), 0);
      chk("t1_busy", 32'(bus.busy), 1);
      bus.req_vec = 4'b0000;
      for (int i = 0; i < 4; i++) step();
      chk("t1_ack_before_resp", 32'(bus.rsc_ack), 1);
      bus.rsc_resp = 1'b1;
      step();
      bus.rsc_resp = 1'b0;
      chk("t1_ack_done", 32'(bus.rsc_ack), 0);
      chk("t1_gnt_done", 32'(bus.gnt_vec), 0);
      chk("t1_busy_done", 32'(bus.busy), 1);
      step();
      chk("t1_busy_idle", 32'(bus.busy), 0);
      chk("t1_req_pulses", 32'(tot_req - s_req), 1);
      chk("t1_ack_cycles", 32'(tot_ack - s_ack), 5);
      chk("t1_timeouts", 32'(tot_to - s_to), 0);

      // Round robin from reset, req 1011 held, each window answered on first WAIT
      reset = 1'b1;
      step();
      reset = 1'b0;
      snap();
      base = grant_log.size();
      bus.req_vec = 4'b1011;
      for (int w = 0; w < 6; w++) begin
         wait_req("rr_start");
         step();
         bus.rsc_resp = 1'b1;
         step();
         bus.rsc_resp = 1'b0;
         if (w == 5) bus.req_vec = 4'b0000;
      end
      step();
      step();
      chk("rr_windows", 32'(grant_log.size() - base), 6);
      for (int k = 0; k < 6; k++) begin
         if (base + k < grant_log.size())
            chk("rr_order", 32'(grant_log[base + k]), 32'(rr_exp[k]));
      end
      chk("rr_multihot", 32'(tot_multihot - s_mh), 0);
      chk("rr_abut", 32'(tot_abut - s_abut), 0);

      // Timeout: no resp, START + 16 WAIT cycles of ack
      snap();
      bus.req_vec = 4'b0010;
      wait_req("to_start");
      bus.req_vec = 4'b0000;
      for (int i = 0; i < 16; i++) step();
      chk("to_ack_last_wait", 32'(bus.rsc_ack), 1);
      chk("to_err_early", 32'(bus.timeout_err), 0);
      step();
      chk("to_err_pulse", 32'(bus.timeout_err), 1);
      chk("to_ack_done", 32'(bus.rsc_ack), 0);
      step();
      chk("to_err_clear", 32'(bus.timeout_err), 0);
      chk("to_busy_idle", 32'(bus.busy), 0);
      chk("to_ack_cycles", 32'(tot_ack - s_ack), 17);
      chk("to_err_count", 32'(tot_to - s_to), 1);

      // Resp on the same cycle the timeout would fire: resp wins
      snap();
      bus.req_vec = 4'b0100;
      wait_req("rt_start");
      chk("rt_gnt_id", 32'(bus.gnt_id), 2);
      bus.req_vec = 4'b0000;
      for (int i = 0; i < 16; i++) step();
      bus.rsc_resp = 1'b1;
      step();
      bus.rsc_resp = 1'b0;
      chk("rt_ack_done", 32'(bus.rsc_ack), 0);
      chk("rt_no_err", 32'(bus.timeout_err), 0);
      step();
      chk("rt_err_count", 32'(tot_to - s_to), 0);
      chk("rt_ack_cycles", 32'(tot_ack - s_ack), 17);

      // Stray responses in IDLE and in START
      snap();
      bus.rsc_resp = 1'b1;
      step();
      bus.rsc_resp = 1'b0;
      chk("st_idle_pulse", 32'(bus.stray_resp), 1);
      chk("st_idle_busy", 32'(bus.busy), 0);
      step();
      chk("st_idle_clear", 32'(bus.stray_resp), 0);
      bus.req_vec = 4'b0001;
      wait_req("st_start");
      bus.req_vec = 4'b0000;
      bus.rsc_resp = 1'b1;
      step();
      bus.rsc_resp = 1'b0;
      chk("st_start_pulse", 32'(bus.stray_resp), 1);
      chk("st_start_ack", 32'(bus.rsc_ack), 1);
      step();
      chk("st_wait_ack", 32'(bus.rsc_ack), 1);
      bus.rsc_resp = 1'b1;
      step();
      bus.rsc_resp = 1'b0;
      chk("st_close_ack", 32'(bus.rsc_ack), 0);
      step();
      chk("st_stray_count", 32'(tot_stray - s_stray), 2);
      chk("st_req_count", 32'(tot_req - s_req), 1);

      // Reset on the 2nd WAIT cycle, then restart from requester 0 priority
      bus.req_vec = 4'b1000;
      wait_req("rm_start");
      chk("rm_gnt_id", 32'(bus.gnt_id), 3);
      bus.req_vec = 4'b0000;
      step();
      step();
      reset = 1'b1;
      step();
      chk("rm_gnt_vec", 32'(bus.gnt_vec), 0);
      chk("rm_gnt_id0", 32'(bus.gnt_id), 0);
      chk("rm_rsc_req", 32'(bus.rsc_req), 0);
      chk("rm_rsc_ack", 32'(bus.rsc_ack), 0);
      chk("rm_busy", 32'(bus.busy), 0);
      chk("rm_timeout", 32'(bus.timeout_err), 0);
      chk("rm_stray", 32'(bus.stray_resp), 0);
      reset = 1'b0;
      bus.req_vec = 4'b0100;
      wait_req("rm_restart");
      chk("rm_new_gnt_vec", 32'(bus.gnt_vec), 32'h4);
      chk("rm_new_gnt_id", 32'(bus.gnt_id), 2);
      bus.req_vec = 4'b0000;
      step();
      bus.rsc_resp = 1'b1;
      step();
      bus.rsc_resp = 1'b0;
      step();
      chk("rm_final_busy", 32'(bus.busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
